// File: rtl/mem_copy_pkg.sv
// Shared types and widths for the memory copy engine.
package mem_copy_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_SH    = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/mem_copy_range_check.sv
// Combinational bounds check: the span [addr/4, addr/4+count) must fit in MEM_WORDS.
module mem_copy_range_check
    import mem_copy_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned CNT_W     = 8
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_ok
);

    // One extra bit so a huge address plus count cannot wrap back into range.
    logic [ADDR_W:0] w_end;

    assign w_end = (ADDR_W+1)'(i_addr >> WORD_SH) + (ADDR_W+1)'(i_count);
    assign o_ok  = (w_end <= (ADDR_W+1)'(MEM_WORDS));

endmodule

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy initiator (one read, one write per word, ascending).
// Optional MEM_COPY_CHECKSUM_EN adds a running sum of written words on port checksum.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  words_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_words_done;
    logic [DATA_W-1:0] r_hold;
    logic              w_src_ok;
    logic              w_dst_ok;
    logic              w_valid;
    logic              w_last;
    logic              w_accept;

    mem_copy_range_check #(.MEM_WORDS(MEM_WORDS), .CNT_W(CNT_W)) u_src_chk (
        .i_addr  (src_addr),
        .i_count (word_count),
        .o_ok    (w_src_ok)
    );

    mem_copy_range_check #(.MEM_WORDS(MEM_WORDS), .CNT_W(CNT_W)) u_dst_chk (
        .i_addr  (dst_addr),
        .i_count (word_count),
        .o_ok    (w_dst_ok)
    );

    assign w_valid  = (src_addr[WORD_SH-1:0] == '0) && (dst_addr[WORD_SH-1:0] == '0)
                      && w_src_ok && w_dst_ok;
    assign w_last   = (CNT_W'(r_words_done + CNT_W'(1)) == r_count);
    assign w_accept = (r_state == IDLE) && start && w_valid;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (!w_valid)             w_next = ERR;
                    else if (word_count == '0) w_next = DONE;
                    else                      w_next = READ;
                end
            end
            READ:    w_next = WRITE;
            WRITE:   w_next = w_last ? DONE : READ;
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = '0;
        data_write = '0;
        case (r_state)
            READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                address  = r_src;
            end
            WRITE: begin
                busy       = 1'b1;
                mem_write  = 1'b1;
                address    = r_dst;
                data_write = r_hold;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Address counters, hold register and progress counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src        <= '0;
            r_dst        <= '0;
            r_count      <= '0;
            r_words_done <= '0;
            r_hold       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_src        <= src_addr;
                        r_dst        <= dst_addr;
                        r_count      <= word_count;
                        r_words_done <= '0;
                    end
                end
                READ:  r_hold <= data_read;
                WRITE: begin
                    r_src        <= r_src + ADDR_W'(WORD_BYTES);
                    r_dst        <= r_dst + ADDR_W'(WORD_BYTES);
                    r_words_done <= r_words_done + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign words_done = r_words_done;

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset)                    r_checksum <= '0;
        else if (w_accept)            r_checksum <= '0;
        else if (r_state == WRITE)    r_checksum <= r_checksum + r_hold;
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench: engine paired with a single-cycle 64-word memory; transaction-level model plus directed checks.
module tb_mem_copy_engine;

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [7:0]  word_count = '0;
    logic        busy, done, error, mem_read, mem_write;
    logic [7:0]  words_done;
    logic [31:0] address, data_write, data_read;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    mem_copy_engine #(.MEM_WORDS(MEM_WORDS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_done (words_done),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .data_write (data_write),
        .data_read  (data_read)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // Single-cycle data memory with bench-side init/preload path.
    logic [31:0] mem [0:63];
    logic        init_en = 1'b1;
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    assign data_read = mem[address[7:2]];

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_write) begin
            mem[address[7:2]] <= data_write;
        end
    end

    typedef struct {
        logic        busy, done, error, rd, wr;
        logic [31:0] addr, wdata;
        logic [7:0]  wd;
        logic [31:0] cs;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [7:0]  idle_wd = '0;
    logic [31:0] idle_cs = '0;
    logic [31:0] exp_mem [0:63];
    bit          armed = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic b, d, e, r, w, input logic [31:0] a, wdat,
                                input logic [7:0] wd, input logic [31:0] cs);
        exp_t x;
        x.busy = b; x.done = d; x.error = e; x.rd = r; x.wr = w;
        x.addr = a; x.wdata = wdat; x.wd = wd; x.cs = cs;
        return x;
    endfunction

    function automatic logic [127:0] pack(input exp_t x);
        logic [31:0] cs;
`ifdef MEM_COPY_CHECKSUM_EN
        cs = x.cs;
`else
        cs = '0;
`endif
        return {19'd0, x.busy, x.done, x.error, x.rd, x.wr, x.addr, x.wdata, x.wd, cs};
    endfunction

    // Turn an accepted request into the full expected cycle trace of the transfer.
    task automatic accept(input logic [31:0] s, d, input logic [7:0] n);
        longint unsigned send, dend;
        logic [31:0]     sh [0:63];
        logic [31:0]     sum, v;
        int              si, di;
        send = longint'(s / 4) + longint'(n);
        dend = longint'(d / 4) + longint'(n);
        if ((s % 4) != 0 || (d % 4) != 0 || send > 64 || dend > 64) begin
            q.push_back(mk(0, 0, 1, 0, 0, 0, 0, idle_wd, idle_cs));
        end else begin
            for (int i = 0; i < 64; i++) sh[i] = mem[i];
            si = int'(s / 4);
            di = int'(d / 4);
            sum = 0;
            for (int i = 0; i < int'(n); i++) begin
                q.push_back(mk(1, 0, 0, 1, 0, s + 32'(4 * i), 0, 8'(i), sum));
                v = sh[si + i];
                q.push_back(mk(1, 0, 0, 0, 1, d + 32'(4 * i), v, 8'(i), sum));
                sh[di + i] = v;
                sum = sum + v;
            end
            q.push_back(mk(1, 1, 0, 0, 0, 0, 0, n, sum));
            idle_wd = n;
            idle_cs = sum;
            for (int i = 0; i < 64; i++) exp_mem[i] = sh[i];
        end
    endtask

    // Model advance: one expected entry per completed cycle; requests only land when idle.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            idle_wd = '0;
            idle_cs = '0;
            armed   = 1'b1;
        end else if (q.size() == 0) begin
            if (start) accept(src_addr, dst_addr, word_count);
        end else begin
            void'(q.pop_front());
        end
    end

    // Per-cycle output comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            if (q.size() > 0) cur = q[0];
            else              cur = mk(0, 0, 0, 0, 0, 0, 0, idle_wd, idle_cs);
            chk("cycle", pack(mk(busy, done, error, mem_read, mem_write, address, data_write,
                                 words_done,
`ifdef MEM_COPY_CHECKSUM_EN
                                 checksum
`else
                                 32'd0
`endif
                                 )), pack(cur));
        end
    end

    int          cyc;
    bit          strobe;
    logic [31:0] cs_done;

    task automatic pulse(input logic [31:0] s, d, input logic [7:0] n);
        @(negedge clk); #1;
        src_addr = s; dst_addr = d; word_count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(output int c, output bit st);
        c = 0;
        st = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (mem_read || mem_write) st = 1'b1;
            if (done || error) begin
                c = i;
`ifdef MEM_COPY_CHECKSUM_EN
                cs_done = checksum;
`endif
                break;
            end
        end
        if (c == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no done/error within 60 cycles");
        end
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge clk); #1;
        pl_en = 1'b1; pl_idx = 6'(idx); pl_data = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic check_mem_model();
        for (int i = 0; i < 64; i++) chk("mem_model", 128'(mem[i]), 128'(exp_mem[i]));
    endtask

    initial begin
        cs_done = '0;
        repeat (2) @(posedge clk);
        #1;
        init_en = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 128'({busy, done, error, mem_read, mem_write, address, data_write, words_done}), 128'(0));
        for (int i = 0; i < 4; i++) preload(i, 32'(i + 1));

        // Misaligned source.
        pulse(32'h02, 32'h40, 8'd1);
        wait_end(cyc, strobe);
        chk("err_align_cycle", 128'(cyc), 128'(1));
        chk("err_align_nostrobe", 128'(strobe), 128'(0));

        // Source span runs past the end of memory.
        pulse(32'hF8, 32'h00, 8'd3);
        wait_end(cyc, strobe);
        chk("err_range_cycle", 128'(cyc), 128'(1));
        chk("err_range_nostrobe", 128'(strobe), 128'(0));

        // Zero-length request.
        pulse(32'h00, 32'h40, 8'd0);
        wait_end(cyc, strobe);
        chk("zero_cycle", 128'(cyc), 128'(1));
        chk("zero_nostrobe", 128'(strobe), 128'(0));

        // Reset during third write of a 4-word copy.
        pulse(32'h00, 32'h40, 8'd4);
        repeat (6) @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", 128'({busy, done, error, mem_read, mem_write, address, data_write, words_done}), 128'(0));
        chk("rst_mid_m16", 128'(mem[16]), 128'(32'd1));
        chk("rst_mid_m17", 128'(mem[17]), 128'(32'd2));
        chk("rst_mid_m18", 128'(mem[18]), 128'(32'd3));
        chk("rst_mid_m19", 128'(mem[19]), 128'(32'hA000_0013));

        // Full 4-word copy.
        pulse(32'h00, 32'h40, 8'd4);
        wait_end(cyc, strobe);
        chk("copy_done_cycle", 128'(cyc), 128'(9));
        chk("copy_words_done", 128'(words_done), 128'(4));
        chk("copy_m19", 128'(mem[19]), 128'(32'd4));
        check_mem_model();

        // Second start while busy is dropped.
        pulse(32'h00, 32'h80, 8'd4);
        repeat (2) @(negedge clk);
        pulse(32'h10, 32'h90, 8'd2);
        wait_end(cyc, strobe);
        chk("busy_words_done", 128'(words_done), 128'(4));
        chk("busy_m35", 128'(mem[35]), 128'(32'd4));
        chk("busy_m36", 128'(mem[36]), 128'(32'hA000_0024));
        check_mem_model();

        // Overlapping ascending copy smears word 0 forward.
        pulse(32'h00, 32'h04, 8'd3);
        wait_end(cyc, strobe);
        chk("overlap_m3", 128'(mem[3]), 128'(32'd1));
        check_mem_model();

        // Wrapping sum of written words.
        preload(40, 32'hFFFF_FFFF);
        preload(41, 32'h0000_0002);
        pulse(32'hA0, 32'hB0, 8'd2);
        wait_end(cyc, strobe);
        chk("cs_copy_m45", 128'(mem[45]), 128'(32'd2));
`ifdef MEM_COPY_CHECKSUM_EN
        chk("checksum_done", 128'(cs_done), 128'(32'h0000_0001));
`endif

        // start and reset on the same edge: reset wins.
        @(negedge clk); #1;
        src_addr = 32'h0; dst_addr = 32'h40; word_count = 8'd2;
        start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("start_reset_busy", 128'(busy), 128'(0));
        chk("start_reset_wd", 128'(words_done), 128'(0));
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
